// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encodings,
// opcode constants, datapath mux/ALU codes and the bundled control-word type.
package mips_ctrl_pkg;

   // State encodings are visible on the debug State port and must stay fixed.
   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAddr = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExec    = 4'd6,
      StRwb     = 4'd7,
      StBranch  = 4'd8,
      StJump    = 4'd9,
      StAddiEx  = 4'd10,
      StAddiWb  = 4'd11,
      StErr     = 4'd15
   } state_t;

   // Instruction opcodes (IR bits [31:26]).
   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   // ALU B-operand select.
   localparam logic [1:0] SrcBRegB   = 2'b00;
   localparam logic [1:0] SrcBFour   = 2'b01;
   localparam logic [1:0] SrcBImm    = 2'b10;
   localparam logic [1:0] SrcBImmSh2 = 2'b11;

   // ALU operation select.
   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpFunct = 2'b10;

   // PC source select.
   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       error;
   } ctrl_t;

   // True in the last cycle of an instruction, i.e. the edge leaving this
   // state retires it. A store only retires once its memory access completes.
   function automatic logic is_retire(state_t st, logic mem_ready);
      logic r;
      r = 1'b0;
      case (st)
         StMemWb, StRwb, StBranch, StJump, StAddiWb: r = 1'b1;
         StMemWr:                                    r = mem_ready;
         default:                                    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control decoder: maps the current FSM state (and the memory
// handshake, which gates the fetch-time IR/PC writes) to the datapath controls.
// Ports:
//   state_i      current FSM state
//   mem_ready_i  memory handshake, access completes in the cycle it is high
//   ctrl_o       full control word; anything not asserted for a state is 0
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t state_i,
   input  logic   mem_ready_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      unique case (state_i)
         StFetch: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SrcBFour;
            ctrl_o.alu_op    = AluOpAdd;
            ctrl_o.pc_source = PcSrcAlu;
            // Latch the instruction and PC+4 only once the fetch has landed.
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         StDecode: begin
            // Precompute the branch target while the opcode is decoded.
            ctrl_o.alu_src_b = SrcBImmSh2;
            ctrl_o.alu_op    = AluOpAdd;
         end
         StMemAddr: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SrcBImm;
            ctrl_o.alu_op    = AluOpAdd;
         end
         StMemRd: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.iord     = 1'b1;
         end
         StMemWb: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         StMemWr: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.iord      = 1'b1;
         end
         StExec: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SrcBRegB;
            ctrl_o.alu_op    = AluOpFunct;
         end
         StRwb: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         StBranch: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SrcBRegB;
            ctrl_o.alu_op        = AluOpSub;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PcSrcAluOut;
         end
         StJump: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PcSrcJump;
         end
         StAddiEx: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SrcBImm;
            ctrl_o.alu_op    = AluOpAdd;
         end
         StAddiWb: begin
            ctrl_o.reg_write = 1'b1;
         end
         StErr: begin
            ctrl_o.error = 1'b1;
         end
         default: begin
            ctrl_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: state register, next-state logic and the
// retired-instruction counter; control outputs come from mips_ctrl_decode.
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   opcode_i             IR[31:26]
//   zero_i               ALU zero flag (consumed by the datapath via PCWriteCond)
//   mem_ready_i          memory handshake
//   pc_write_o .. alu_src_a_o  single-bit datapath enables/selects
//   alu_src_b_o, alu_op_o, pc_source_o  2-bit datapath selects
//   state_o              current state, for debug
//   error_o              sticky illegal-opcode flag
//   instr_count_o        retired-instruction count, wraps silently
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             pc_write_cond_o,
   output logic             iord_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             ir_write_o,
   output logic             mem_to_reg_o,
   output logic             reg_write_o,
   output logic             reg_dst_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic [1:0]       pc_source_o,
   output logic [3:0]       state_o,
   output logic             error_o,
   output logic [CNT_W-1:0] instr_count_o
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   ctrl_t            dec_ctrl;
   ctrl_t            ctrl;

   // Branch resolution happens in the datapath (PCWriteCond & Zero).
   logic unused_zero;
   assign unused_zero = zero_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StFetch;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:   if (mem_ready_i) state_d = StDecode;
         StDecode: begin
            unique case (opcode_i)
               OpLw, OpSw: state_d = StMemAddr;
               OpRType:    state_d = StExec;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpAddi:     state_d = StAddiEx;
               default:    state_d = StErr;
            endcase
         end
         StMemAddr: begin
            if (opcode_i == OpLw)      state_d = StMemRd;
            else if (opcode_i == OpSw) state_d = StMemWr;
            else                       state_d = StErr;
         end
         StMemRd:   if (mem_ready_i) state_d = StMemWb;
         StMemWr:   if (mem_ready_i) state_d = StFetch;
         StExec:    state_d = StRwb;
         StAddiEx:  state_d = StAddiWb;
         StMemWb, StRwb, StBranch, StJump, StAddiWb: state_d = StFetch;
         StErr:     state_d = StErr;
         default:   state_d = StErr;
      endcase
   end

   always_comb begin
      instr_count_d = instr_count_q;
      if (is_retire(state_q, mem_ready_i)) begin
         instr_count_d = instr_count_q + CNT_W'(1);
      end
   end

   mips_ctrl_decode u_decode (
      .state_i     (state_q),
      .mem_ready_i (mem_ready_i),
      .ctrl_o      (dec_ctrl)
   );

   // Reset parks the FSM in FETCH, which would otherwise drive MemRead; hold
   // every memory/register/PC enable low for as long as reset is asserted.
   always_comb begin
      ctrl = dec_ctrl;
      if (!rst_n) begin
         ctrl.pc_write      = 1'b0;
         ctrl.pc_write_cond = 1'b0;
         ctrl.ir_write      = 1'b0;
         ctrl.mem_read      = 1'b0;
         ctrl.mem_write     = 1'b0;
         ctrl.reg_write     = 1'b0;
      end
   end

   assign pc_write_o      = ctrl.pc_write;
   assign pc_write_cond_o = ctrl.pc_write_cond;
   assign iord_o          = ctrl.iord;
   assign mem_read_o      = ctrl.mem_read;
   assign mem_write_o     = ctrl.mem_write;
   assign ir_write_o      = ctrl.ir_write;
   assign mem_to_reg_o    = ctrl.mem_to_reg;
   assign reg_write_o     = ctrl.reg_write;
   assign reg_dst_o       = ctrl.reg_dst;
   assign alu_src_a_o     = ctrl.alu_src_a;
   assign alu_src_b_o     = ctrl.alu_src_b;
   assign alu_op_o        = ctrl.alu_op;
   assign pc_source_o     = ctrl.pc_source;
   assign error_o         = ctrl.error;
   assign state_o         = state_q;
   assign instr_count_o   = instr_count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. A second instance with CNT_W=4
// shares all inputs so counter wrap can be observed.
module tb_mips_multicycle_ctrl;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_write, reg_dst, alu_src_a, error;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic [31:0] count;

   logic        w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write, w_ir_write;
   logic        w_mem_to_reg, w_reg_write, w_reg_dst, w_alu_src_a, w_error;
   logic [1:0]  w_alu_src_b, w_alu_op, w_pc_source;
   logic [3:0]  w_state;
   logic [3:0]  count4;

   int n_cmp = 0;
   int n_bad = 0;

   mips_multicycle_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .opcode_i        (opcode),
      .zero_i          (zero),
      .mem_ready_i     (mem_ready),
      .pc_write_o      (pc_write),
      .pc_write_cond_o (pc_write_cond),
      .iord_o          (iord),
      .mem_read_o      (mem_read),
      .mem_write_o     (mem_write),
      .ir_write_o      (ir_write),
      .mem_to_reg_o    (mem_to_reg),
      .reg_write_o     (reg_write),
      .reg_dst_o       (reg_dst),
      .alu_src_a_o     (alu_src_a),
      .alu_src_b_o     (alu_src_b),
      .alu_op_o        (alu_op),
      .pc_source_o     (pc_source),
      .state_o         (state),
      .error_o         (error),
      .instr_count_o   (count)
   );

   mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
      .clk             (clk),
      .rst_n           (rst_n),
      .opcode_i        (opcode),
      .zero_i          (zero),
      .mem_ready_i     (mem_ready),
      .pc_write_o      (w_pc_write),
      .pc_write_cond_o (w_pc_write_cond),
      .iord_o          (w_iord),
      .mem_read_o      (w_mem_read),
      .mem_write_o     (w_mem_write),
      .ir_write_o      (w_ir_write),
      .mem_to_reg_o    (w_mem_to_reg),
      .reg_write_o     (w_reg_write),
      .reg_dst_o       (w_reg_dst),
      .alu_src_a_o     (w_alu_src_a),
      .alu_src_b_o     (w_alu_src_b),
      .alu_op_o        (w_alu_op),
      .pc_source_o     (w_pc_source),
      .state_o         (w_state),
      .error_o         (w_error),
      .instr_count_o   (count4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'b000000;
      zero      = 1'b0;
      mem_ready = 1'b1;
      #3;
      // During reset: FETCH, cleared count/error, enables held low.
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", count, 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_ir_write", 32'(ir_write), 32'd0);
      chk("rst_pc_write", 32'(pc_write), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("fetch_mem_read", 32'(mem_read), 32'd1);
      chk("fetch_ir_write", 32'(ir_write), 32'd1);
      chk("fetch_pc_write", 32'(pc_write), 32'd1);
      chk("fetch_srcb", 32'(alu_src_b), 32'd1);

      // R-type: 0,1,6,7,0
      step();
      chk("r_s1", 32'(state), 32'd1);
      chk("r_dec_srcb", 32'(alu_src_b), 32'd3);
      step();
      chk("r_s6", 32'(state), 32'd6);
      chk("r_exec_aluop", 32'(alu_op), 32'd2);
      chk("r_exec_srca", 32'(alu_src_a), 32'd1);
      step();
      chk("r_s7", 32'(state), 32'd7);
      chk("r_regdst", 32'(reg_dst), 32'd1);
      chk("r_regwrite", 32'(reg_write), 32'd1);
      chk("r_memtoreg", 32'(mem_to_reg), 32'd0);
      step();
      chk("r_s0", 32'(state), 32'd0);
      chk("r_count", count, 32'd1);

      // lw with 3 wait cycles in MEMRD
      opcode = 6'b100011;
      step();
      chk("lw_s1", 32'(state), 32'd1);
      step();
      chk("lw_s2", 32'(state), 32'd2);
      chk("lw_addr_srcb", 32'(alu_src_b), 32'd2);
      mem_ready = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("lw_hold_state", 32'(state), 32'd3);
         chk("lw_hold_regwrite", 32'(reg_write), 32'd0);
         chk("lw_hold_irwrite", 32'(ir_write), 32'd0);
         chk("lw_hold_iord", 32'(iord), 32'd1);
         step();
      end
      mem_ready = 1'b1;
      #1;
      chk("lw_last_rd", 32'(state), 32'd3);
      chk("lw_last_memread", 32'(mem_read), 32'd1);
      step();
      chk("lw_s4", 32'(state), 32'd4);
      chk("lw_wb_regwrite", 32'(reg_write), 32'd1);
      chk("lw_wb_memtoreg", 32'(mem_to_reg), 32'd1);
      chk("lw_wb_count", count, 32'd1);
      step();
      chk("lw_s0", 32'(state), 32'd0);
      chk("lw_count", count, 32'd2);

      // beq: 3 cycles
      opcode = 6'b000100;
      zero   = 1'b1;
      step();
      chk("beq_s1", 32'(state), 32'd1);
      chk("beq_dec_srcb", 32'(alu_src_b), 32'd3);
      step();
      chk("beq_s8", 32'(state), 32'd8);
      chk("beq_pcwc", 32'(pc_write_cond), 32'd1);
      chk("beq_pcsrc", 32'(pc_source), 32'd1);
      chk("beq_aluop", 32'(alu_op), 32'd1);
      chk("beq_pcwrite", 32'(pc_write), 32'd0);
      step();
      chk("beq_s0", 32'(state), 32'd0);
      chk("beq_count", count, 32'd3);
      zero = 1'b0;

      // sw, zero wait
      opcode = 6'b101011;
      step();
      step();
      chk("sw_s2", 32'(state), 32'd2);
      step();
      chk("sw_s5", 32'(state), 32'd5);
      chk("sw_memwrite", 32'(mem_write), 32'd1);
      chk("sw_iord", 32'(iord), 32'd1);
      step();
      chk("sw_s0", 32'(state), 32'd0);
      chk("sw_count", count, 32'd4);

      // addi
      opcode = 6'b001000;
      step();
      step();
      chk("addi_s10", 32'(state), 32'd10);
      chk("addi_srcb", 32'(alu_src_b), 32'd2);
      step();
      chk("addi_s11", 32'(state), 32'd11);
      chk("addi_regwrite", 32'(reg_write), 32'd1);
      chk("addi_regdst", 32'(reg_dst), 32'd0);
      step();
      chk("addi_count", count, 32'd5);

      // FETCH memory wait
      mem_ready = 1'b0;
      #1;
      chk("fwait_irwrite", 32'(ir_write), 32'd0);
      chk("fwait_pcwrite", 32'(pc_write), 32'd0);
      chk("fwait_memread", 32'(mem_read), 32'd1);
      step();
      chk("fwait_state", 32'(state), 32'd0);
      mem_ready = 1'b1;

      // Reset asserted during a store wait
      opcode = 6'b101011;
      step();
      step();
      mem_ready = 1'b0;
      step();
      chk("swr_s5", 32'(state), 32'd5);
      step();
      chk("swr_hold", 32'(state), 32'd5);
      chk("swr_hold_count", count, 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("swr_memwrite", 32'(mem_write), 32'd0);
      chk("swr_count", count, 32'd0);
      chk("swr_state", 32'(state), 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Illegal opcode
      opcode = 6'b111111;
      step();
      step();
      chk("err_state", 32'(state), 32'd15);
      for (int i = 0; i < 10; i++) begin
         chk("err_flag", 32'(error), 32'd1);
         chk("err_state_hold", 32'(state), 32'd15);
         chk("err_enables", 32'({mem_read, mem_write, reg_write, pc_write,
                                 pc_write_cond, ir_write}), 32'd0);
         step();
      end
      chk("err_count", count, 32'd0);
      rst_n = 1'b0;
      #2;
      chk("err_rst_state", 32'(state), 32'd0);
      chk("err_rst_flag", 32'(error), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 16 jumps: 4-bit counter wraps 15 -> 0
      opcode = 6'b000010;
      for (int i = 0; i < 16; i++) begin
         step();
         step();
         if (i == 0) begin
            chk("j_s9", 32'(state), 32'd9);
            chk("j_pcwrite", 32'(pc_write), 32'd1);
            chk("j_pcsrc", 32'(pc_source), 32'd2);
         end
         step();
         if (i == 14) chk("wrap_15", 32'(count4), 32'd15);
      end
      chk("wrap_0", 32'(count4), 32'd0);
      chk("wrap_wide", count, 32'd16);
      chk("wrap_state", 32'(state), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
